// File: rtl/dma_arb_pkg.sv
// Shared constants for the DMA channel arbiter: FSM encoding, default size width
// and an elaboration-time log2 helper.
package dma_arb_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam int unsigned DEFAULT_SIZE_W = 4;

   // Bits needed to index `value` items; never less than one.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 1;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/dma_rr_picker.sv
// Combinational round-robin picker: first set request at or above rr_ptr, wrapping.
module dma_rr_picker
   import dma_arb_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   parameter int unsigned ID_W = clog2(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic            valid,
   output logic [N_CH-1:0] pick,
   output logic [ID_W-1:0] idx
);

   logic [ID_W-1:0] cand;

   always_comb begin
      valid = 1'b0;
      idx   = '0;
      pick  = '0;
      cand  = '0;
      // Scan from the farthest offset down so the nearest hit is the last one written.
      for (int i = int'(N_CH) - 1; i >= 0; i--) begin
         cand = ID_W'((int'(rr_ptr) + i) % int'(N_CH));
         if (req[cand]) begin
            valid = 1'b1;
            idx   = cand;
         end
      end
      if (valid) pick[idx] = 1'b1;
   end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin scheduler sharing one DMA engine between N_CH channels.
// Optional WAIT-state timeout is enabled by defining DMA_ARB_TIMEOUT_EN.
module dma_arbiter
   import dma_arb_pkg::*;
#(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned SIZE_W      = DEFAULT_SIZE_W,
   parameter int unsigned TIMEOUT_CYC = 64,
   localparam int unsigned ID_W       = clog2(N_CH)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [N_CH-1:0]        req,
   input  logic [N_CH*SIZE_W-1:0] size_in,
   output logic [N_CH-1:0]        ack,
   output logic [N_CH-1:0]        grant,
   output logic [ID_W-1:0]        gnt_id,
   output logic                   busy,
   output logic                   dma_start,
   output logic [SIZE_W-1:0]      dma_size,
   input  logic                   dma_done,
   output logic                   err
);

   logic [1:0]        state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_CH-1:0]   grant_q, grant_d;
   logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
   logic [SIZE_W-1:0] size_q, size_d;
   logic [N_CH-1:0]   ack_q, ack_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;

   logic              pick_valid;
   logic [N_CH-1:0]   pick;
   logic [ID_W-1:0]   pick_idx;
   logic [SIZE_W-1:0] sel_size;

`ifdef DMA_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
`endif

   dma_rr_picker #(
      .N_CH (N_CH),
      .ID_W (ID_W)
   ) u_picker (
      .req    (req),
      .rr_ptr (rr_ptr_q),
      .valid  (pick_valid),
      .pick   (pick),
      .idx    (pick_idx)
   );

   assign sel_size = size_in[int'(pick_idx) * int'(SIZE_W) +: SIZE_W];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      gnt_id_d = gnt_id_q;
      size_d   = size_q;
      ack_d    = '0;
      start_d  = 1'b0;
`ifdef DMA_ARB_TIMEOUT_EN
      cnt_d    = cnt_q;
      err_d    = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (pick_valid) begin
               grant_d  = pick;
               gnt_id_d = pick_idx;
               size_d   = sel_size;
               // Zero-length transfers skip the engine and acknowledge directly.
               if (sel_size != '0) begin
                  state_d = ST_START;
                  start_d = 1'b1;
               end else begin
                  state_d = ST_DONE;
                  ack_d   = pick;
               end
            end
         end
         ST_START: begin
            state_d = ST_WAIT;
`ifdef DMA_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         ST_WAIT: begin
            if (dma_done) begin
               state_d = ST_DONE;
               ack_d   = grant_q;
`ifdef DMA_ARB_TIMEOUT_EN
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               state_d = ST_DONE;
               ack_d   = grant_q;
               err_d   = 1'b1;
            end else begin
               cnt_d   = cnt_q + 1'b1;
`endif
            end
         end
         ST_DONE: begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            gnt_id_d = '0;
            rr_ptr_d = (gnt_id_q == ID_W'(N_CH - 1)) ? '0 : gnt_id_q + 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         gnt_id_q <= '0;
         size_q   <= '0;
         ack_q    <= '0;
         start_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         gnt_id_q <= gnt_id_d;
         size_q   <= size_d;
         ack_q    <= ack_d;
         start_q  <= start_d;
         busy_q   <= busy_d;
      end
   end

`ifdef DMA_ARB_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   assign ack       = ack_q;
   assign grant     = grant_q;
   assign gnt_id    = gnt_id_q;
   assign busy      = busy_q;
   assign dma_start = start_q;
   assign dma_size  = size_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter with grant/ack scoreboards and a simple engine model.
module tb_dma_arbiter;

   localparam int unsigned N_CH        = 4;
   localparam int unsigned SIZE_W      = 4;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic                   clk = 1'b0;
   logic                   reset_n = 1'b0;
   logic [N_CH-1:0]        req = '0;
   logic [N_CH*SIZE_W-1:0] size_in = '0;
   logic [N_CH-1:0]        ack;
   logic [N_CH-1:0]        grant;
   logic [1:0]             gnt_id;
   logic                   busy;
   logic                   dma_start;
   logic [SIZE_W-1:0]      dma_size;
   logic                   dma_done;
   logic                   err;

   logic eng_done  = 1'b0;
   logic tb_done   = 1'b0;
   logic engine_en = 1'b1;
   logic last_done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;
   int n_starts = 0;

   logic [N_CH-1:0] exp_grant_q[$];
   logic [N_CH-1:0] exp_ack_q[$];

   assign dma_done = eng_done | tb_done;

   always #5 clk = ~clk;

   dma_arbiter #(
      .N_CH        (N_CH),
      .SIZE_W      (SIZE_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req       (req),
      .size_in   (size_in),
      .ack       (ack),
      .grant     (grant),
      .gnt_id    (gnt_id),
      .busy      (busy),
      .dma_start (dma_start),
      .dma_size  (dma_size),
      .dma_done  (dma_done),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Engine model: done pulses for one cycle, eight cycles after the start pulse.
   initial forever begin
      @(negedge clk);
      if (dma_start && engine_en) begin
         repeat (8) @(negedge clk);
         eng_done = 1'b1;
         @(negedge clk);
         eng_done = 1'b0;
      end
   end

   // dma_done as seen by the DUT at the edge that opened the current cycle.
   always @(posedge clk) last_done = dma_done;

   // Scoreboard: grants popped on each start pulse, acks popped on each ack pulse.
   always @(negedge clk) begin
      if (reset_n) begin
         if (dma_start) begin
            n_starts++;
            if (exp_grant_q.size() == 0) check("grant_unexpected", 32'(grant), 32'd0);
            else check("grant_order", 32'(grant), 32'(exp_grant_q.pop_front()));
         end
         if (ack !== '0) begin
            if (exp_ack_q.size() == 0) check("ack_unexpected", 32'(ack), 32'd0);
            else check("ack_order", 32'(ack), 32'(exp_ack_q.pop_front()));
         end
      end
   end

   task automatic wait_ack(input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (ack !== '0) break;
      end
      check({tag, "_ack_seen"}, 32'(ack !== '0), 32'd1);
   endtask

   task automatic wait_start(input int budget, input string tag);
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (dma_start) break;
      end
      check({tag, "_start_seen"}, 32'(dma_start), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int s0;
      logic [N_CH-1:0] served;

      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({grant, gnt_id, busy, dma_start, dma_size, ack, err}), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // Single transfer on ch2, size 4
      size_in = 16'h1432;
      req = 4'b0100;
      exp_grant_q.push_back(4'b0100);
      exp_ack_q.push_back(4'b0100);
      s0 = n_starts;
      @(negedge clk);
      check("t1_start", 32'(dma_start), 32'd1);
      check("t1_gnt_id", 32'(gnt_id), 32'd2);
      check("t1_size", 32'(dma_size), 32'd4);
      check("t1_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("t1_start_once", 32'(dma_start), 32'd0);
      wait_ack(20, "t1");
      check("t1_ack_after_done", 32'(last_done), 32'd1);
      req = '0;
      @(negedge clk);
      check("t1_idle", 32'({busy, grant}), 32'd0);
      check("t1_start_count", 32'(n_starts - s0), 32'd1);

      // Fairness with all channels requesting from reset release
      reset_n = 1'b0;
      req = 4'b1111;
      @(negedge clk);
      reset_n = 1'b1;
      s0 = n_starts;
      for (int k = 0; k < 6; k++) begin
         exp_grant_q.push_back(4'b0001 << (k % 4));
         exp_ack_q.push_back(4'b0001 << (k % 4));
      end
      for (int k = 0; k < 6; k++) begin
         wait_ack(30, "t2");
         served = ack;
         req = (k == 5) ? '0 : (req & ~served);
         @(negedge clk);
         if (k < 5) req = req | served;
      end
      check("t2_start_count", 32'(n_starts - s0), 32'd6);
      check("t2_all_acked", 32'(exp_ack_q.size()), 32'd0);

      // Zero-size request on ch1 bypasses the engine
      size_in = 16'h1402;
      req = 4'b0010;
      exp_ack_q.push_back(4'b0010);
      s0 = n_starts;
      wait_ack(1, "t3");
      req = '0;
      check("t3_no_start", 32'(n_starts - s0), 32'd0);
      @(negedge clk);
      check("t3_idle", 32'(busy), 32'd0);

      // Asynchronous reset in WAIT, then simultaneous requests go to ch0
      req = 4'b1000;
      exp_grant_q.push_back(4'b1000);
      exp_ack_q.push_back(4'b1000);
      wait_start(5, "t4");
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      check("t4_async_reset", 32'({grant, gnt_id, busy, dma_start, dma_size, ack, err}), 32'd0);
      exp_ack_q.delete();
      exp_grant_q.delete();
      repeat (12) @(negedge clk);
      req = 4'b1111;
      reset_n = 1'b1;
      exp_grant_q.push_back(4'b0001);
      exp_ack_q.push_back(4'b0001);
      @(negedge clk);
      check("t4_gnt_id_ch0", 32'(gnt_id), 32'd0);
      wait_ack(20, "t4");
      req = '0;
      @(negedge clk);

      // dma_done while idle is ignored; req drop and size change during WAIT are ignored
      tb_done = 1'b1;
      @(negedge clk);
      tb_done = 1'b0;
      check("t5_done_idle", 32'({busy, dma_start, grant}), 32'd0);
      req = 4'b0100;
      exp_grant_q.push_back(4'b0100);
      exp_ack_q.push_back(4'b0100);
      wait_start(5, "t5");
      @(negedge clk);
      req = '0;
      size_in[11:8] = 4'hA;
      @(negedge clk);
      check("t5_size_hold", 32'(dma_size), 32'd4);
      check("t5_busy", 32'(busy), 32'd1);
      wait_ack(20, "t5");
      @(negedge clk);
      check("t5_idle", 32'(busy), 32'd0);

      // Engine never completes
      engine_en = 1'b0;
      size_in[3:0] = 4'h2;
      req = 4'b0001;
      exp_grant_q.push_back(4'b0001);
`ifdef DMA_ARB_TIMEOUT_EN
      exp_ack_q.push_back(4'b0001);
      wait_start(5, "t6");
      repeat (16) @(negedge clk);
      check("t6_pre_timeout", 32'({ack, err}), 32'd0);
      @(negedge clk);
      check("t6_err", 32'(err), 32'd1);
      check("t6_ack", 32'(ack), 32'd1);
      req = '0;
      @(negedge clk);
      check("t6_idle", 32'({busy, err}), 32'd0);
`else
      wait_start(5, "t6");
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         check("t6_hang", 32'({busy, err}), 32'd2);
      end
      req = '0;
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
`endif
      engine_en = 1'b1;
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
